// File: rtl/alu_flag_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_flag_unit_pkg
// Shared ALU definitions: the operation encoding seen by the flag unit and the
// condition helper that turns raw sign/zero information into the branch /
// set-less-than result. Any later flag consumer should reuse cond_from_flags.
// -----------------------------------------------------------------------------
package alu_flag_unit_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_EQ  = 3'd2,
        ALU_NE  = 3'd3,
        ALU_LT  = 3'd4,
        ALU_GE  = 3'd5,
        ALU_LTU = 3'd6,
        ALU_GEU = 3'd7
    } ALUOp_t;

    // n    : msb of the difference a - b
    // a, b : msbs of the two source operands
    // zacc : 1 when every result slice was zero
    // When the operand signs differ the subtraction can overflow, so the
    // ordering is decided by the operand msbs instead of the result sign.
    function automatic logic cond_from_flags(input ALUOp_t op,
                                             input logic   n,
                                             input logic   a,
                                             input logic   b,
                                             input logic   zacc);
        logic sign_diff;
        logic lt;
        logic ltu;
        logic c;
        sign_diff = a ^ b;
        lt        = sign_diff ? a : n;
        ltu       = sign_diff ? b : n;
        case (op)
            ALU_EQ:  c = zacc;
            ALU_NE:  c = ~zacc;
            ALU_LT:  c = lt;
            ALU_GE:  c = ~lt;
            ALU_LTU: c = ltu;
            ALU_GEU: c = ~ltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_flag_unit_chk.sv
// -----------------------------------------------------------------------------
// alu_flag_unit_chk
// Simulation-only protocol observer for alu_flag_unit. Reports a new start
// while a capture is still running, and an adder done strobe that disagrees
// with the slice counter. Both are recoverable (the unit ignores the stray
// start and trusts its own counter), so they are reported as warnings.
// Ports:
//   clk, rst  : clock and synchronous active-high reset of the observed unit
//   start     : raw start input
//   busy      : capture-in-progress state
//   add_done  : adder done strobe
//   active    : unit is capturing a slice this cycle
//   last      : this cycle carries the final slice according to the counter
// -----------------------------------------------------------------------------
module alu_flag_unit_chk (
    input logic clk,
    input logic rst,
    input logic start,
    input logic busy,
    input logic add_done,
    input logic active,
    input logic last
);

    // Sample the handshake once per cycle outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(start && busy))
                else $warning("alu_flag_unit: start while busy, ignored");
            assert (!active || (add_done == last))
                else $warning("alu_flag_unit: add_done disagrees with slice counter");
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// -----------------------------------------------------------------------------
// alu_flag_unit
// Collects the slices produced by the multi-cycle sliced adder, assembles the
// full result, accumulates a zero flag and derives the comparison condition
// for the latched operation. Result, zero and cond are published together with
// a one-cycle result_valid pulse NCYC cycles after start.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   start        : start pulse shared with the adder; marks slice 0
//   op           : ALU operation, sampled on start
//   add_out      : adder output bus (one valid WADD-bit slice per cycle)
//   add_done     : adder done strobe (expected on the last slice)
//   src_a_msb    : msb of adder operand a
//   src_b_msb    : msb of adder operand b
//   result       : assembled result, held until the next result_valid
//   zero         : result == 0
//   cond         : condition for the latched op (0 for ADD/SUB)
//   result_valid : one-cycle pulse when result/zero/cond update
//   busy         : capture in progress
// -----------------------------------------------------------------------------
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WADD  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  ALUOp_t           op,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_done,
    input  logic             src_a_msb,
    input  logic             src_b_msb,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cond,
    output logic             result_valid,
    output logic             busy
);

    localparam int NCYC = (WIDTH + WADD - 1) / WADD;
    localparam int WCYC = (NCYC > 1) ? $clog2(NCYC) : 1;
    // The bus is viewed as NCYC full slices; a short top slice is zero-padded.
    localparam int WEXT = NCYC * WADD;
    localparam logic [WCYC-1:0] LAST_IDX = WCYC'(NCYC - 1);

    // Registered state
    logic [WCYC-1:0]  cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    ALUOp_t           op_q,     op_d;
    logic [WEXT-1:0]  acc_q,    acc_d;
    logic             zacc_q,   zacc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             cond_q,   cond_d;
    logic             valid_q,  valid_d;

    // Per-cycle decode
    logic             start_eff_s;
    logic             active_s;
    logic             last_s;
    logic [WCYC-1:0]  idx_s;
    ALUOp_t           op_cur_s;
    logic [WEXT-1:0]  add_ext_s;
    logic [WEXT-1:0]  acc_next_s;
    logic [WADD-1:0]  slice_s;
    logic             zacc_next_s;

    // Decode the active slice and merge it into the partial result.
    always_comb begin
        // A start during a capture is a protocol violation and is dropped.
        start_eff_s = start & ~busy_q;
        active_s    = start_eff_s | busy_q;
        idx_s       = busy_q ? cnt_q : {WCYC{1'b0}};
        op_cur_s    = busy_q ? op_q : op;
        last_s      = active_s & (idx_s == LAST_IDX);
        add_ext_s   = WEXT'(add_out);
        acc_next_s  = acc_q;
        slice_s     = {WADD{1'b0}};
        for (int s = 0; s < NCYC; s++) begin
            acc_next_s[s*WADD +: WADD] = (idx_s == WCYC'(s)) ? add_ext_s[s*WADD +: WADD]
                                                             : acc_q[s*WADD +: WADD];
            slice_s = slice_s | (add_ext_s[s*WADD +: WADD] & {WADD{idx_s == WCYC'(s)}});
        end
        // The zero accumulator restarts on the start cycle.
        zacc_next_s = (busy_q ? zacc_q : 1'b1) & (slice_s == {WADD{1'b0}});
    end

    // Next-state for counter, capture buffer and published outputs.
    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        acc_d    = acc_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        zero_d   = zero_q;
        cond_d   = cond_q;
        valid_d  = 1'b0;
        if (last_s) begin
            cnt_d    = {WCYC{1'b0}};
            busy_d   = 1'b0;
            acc_d    = acc_next_s;
            zacc_d   = zacc_next_s;
            result_d = acc_next_s[WIDTH-1:0];
            zero_d   = zacc_next_s;
            // add_out's msb is valid here: the top slice is on the bus.
            cond_d   = cond_from_flags(op_cur_s, add_out[WIDTH-1],
                                       src_a_msb, src_b_msb, zacc_next_s);
            valid_d  = 1'b1;
        end else if (active_s) begin
            cnt_d  = idx_s + WCYC'(1);
            busy_d = 1'b1;
            acc_d  = acc_next_s;
            zacc_d = zacc_next_s;
        end else begin
            valid_d = 1'b0;
        end
        if (start_eff_s) begin
            op_d = op;
        end else begin
            op_d = op_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= {WCYC{1'b0}};
            busy_q   <= 1'b0;
            op_q     <= ALU_ADD;
            acc_q    <= {WEXT{1'b0}};
            zacc_q   <= 1'b1;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
            cond_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cond_q   <= cond_d;
            valid_q  <= valid_d;
        end
    end

    assign result       = result_q;
    assign zero         = zero_q;
    assign cond         = cond_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

    alu_flag_unit_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy_q),
        .add_done (add_done),
        .active   (active_s),
        .last     (last_s)
    );

endmodule

// File: tb/tb_alu_flag_unit.sv
module tb_alu_flag_unit;
    import alu_flag_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Two-slice build (WADD=16)
    logic        start = 1'b0;
    ALUOp_t      op = ALU_ADD;
    logic [31:0] add_out = 32'd0;
    logic        add_done = 1'b0;
    logic        a_msb = 1'b0;
    logic        b_msb = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        cond;
    logic        result_valid;
    logic        busy;

    // Single-slice build (WADD=32)
    logic        start1 = 1'b0;
    ALUOp_t      op1 = ALU_ADD;
    logic [31:0] add_out1 = 32'd0;
    logic        add_done1 = 1'b0;
    logic        a_msb1 = 1'b0;
    logic        b_msb1 = 1'b0;
    logic [31:0] result1;
    logic        zero1;
    logic        cond1;
    logic        result_valid1;
    logic        busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_flag_unit #(.WIDTH(32), .WADD(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .add_out(add_out),
        .add_done(add_done), .src_a_msb(a_msb), .src_b_msb(b_msb),
        .result(result), .zero(zero), .cond(cond),
        .result_valid(result_valid), .busy(busy)
    );

    alu_flag_unit #(.WIDTH(32), .WADD(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .add_out(add_out1),
        .add_done(add_done1), .src_a_msb(a_msb1), .src_b_msb(b_msb1),
        .result(result1), .zero(zero1), .cond(cond1),
        .result_valid(result_valid1), .busy(busy1)
    );

    // Reference: what the adder computes for this op.
    function automatic logic [31:0] ref_sum(input ALUOp_t o, input logic [31:0] a, input logic [31:0] b);
        return (o == ALU_ADD) ? a + b : a - b;
    endfunction

    // Reference: the architectural meaning of each comparison.
    function automatic logic ref_cond(input ALUOp_t o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            ALU_EQ:  return a == b;
            ALU_NE:  return a != b;
            ALU_LT:  return $signed(a) < $signed(b);
            ALU_GE:  return $signed(a) >= $signed(b);
            ALU_LTU: return a < b;
            ALU_GEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One full operation on the two-slice unit; optionally an idle cycle after.
    task automatic apply_op(input ALUOp_t o, input logic [31:0] a, input logic [31:0] b, input bit idle_after);
        logic [31:0] s;
        logic        c;
        s = ref_sum(o, a, b);
        c = ref_cond(o, a, b);
        // T0: low slice correct, high slice is src_a pass-through
        start = 1'b1; op = o; add_done = 1'b0;
        add_out = {a[31:16], s[15:0]}; a_msb = a[31]; b_msb = b[31];
        @(posedge clk); #1;
        n_vec++;
        if (result_valid !== 1'b0) begin n_err++; $display("FAIL early_valid: got %b want 0 (op %s)", result_valid, o.name()); end
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_mid: got %b want 1", busy); end
        // T1: high slice correct, low slice is src_a pass-through; op input scrambled
        start = 1'b0; op = ALUOp_t'($urandom_range(0, 7)); add_done = 1'b1;
        add_out = {s[31:16], a[15:0]};
        @(posedge clk); #1;
        n_vec++;
        if (result_valid !== 1'b1) begin n_err++; $display("FAIL valid: got %b want 1 (op %s)", result_valid, o.name()); end
        n_vec++;
        if (result !== s) begin n_err++; $display("FAIL result: got %h want %h (op %s a %h b %h)", result, s, o.name(), a, b); end
        n_vec++;
        if (zero !== (s == 32'd0)) begin n_err++; $display("FAIL zero: got %b want %b (op %s a %h b %h)", zero, (s == 32'd0), o.name(), a, b); end
        n_vec++;
        if (cond !== c) begin n_err++; $display("FAIL cond: got %b want %b (op %s a %h b %h)", cond, c, o.name(), a, b); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_done: got %b want 0", busy); end
        add_done = 1'b0; add_out = $urandom;
        if (idle_after) begin
            @(posedge clk); #1;
            n_vec++;
            if (result_valid !== 1'b0) begin n_err++; $display("FAIL valid_pulse: got %b want 0", result_valid); end
            n_vec++;
            if (result !== s) begin n_err++; $display("FAIL result_hold: got %h want %h", result, s); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({result, zero, cond, result_valid, busy} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset2: got r=%h z=%b c=%b v=%b b=%b", result, zero, cond, result_valid, busy);
        end
        n_vec++;
        if ({result1, zero1, cond1, result_valid1, busy1} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset1: got r=%h z=%b c=%b v=%b b=%b", result1, zero1, cond1, result_valid1, busy1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        apply_op(ALU_ADD, 32'h0000FFFF, 32'h00000001, 1'b1);
        apply_op(ALU_EQ,  32'h00010000, 32'h00010000, 1'b1);
        apply_op(ALU_EQ,  32'h00010000, 32'h00000000, 1'b1);
        apply_op(ALU_NE,  32'h00010000, 32'h00000000, 1'b1);
        apply_op(ALU_LT,  32'h00000001, 32'h80000000, 1'b1);
        apply_op(ALU_LTU, 32'h00000001, 32'h80000000, 1'b1);
        apply_op(ALU_LT,  32'hFFFFFFFF, 32'h00000001, 1'b1);
        apply_op(ALU_GEU, 32'hFFFFFFFF, 32'h00000001, 1'b1);
        apply_op(ALU_LT,  32'd5, 32'd7, 1'b1);
        apply_op(ALU_GE,  32'd7, 32'd5, 1'b1);
        apply_op(ALU_LTU, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
        apply_op(ALU_SUB, 32'h12345678, 32'h12345678, 1'b1);
    endtask

    task automatic test_back_to_back();
        apply_op(ALU_SUB, 32'h00020000, 32'h00000001, 1'b0);
        apply_op(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        apply_op(ALU_GE,  32'h80000000, 32'h00000000, 1'b1);
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        a = 32'h00000001; b = 32'h80000000; s = a - b;
        start = 1'b1; op = ALU_LTU; add_done = 1'b0;
        add_out = {a[31:16], s[15:0]}; a_msb = a[31]; b_msb = b[31];
        @(posedge clk); #1;
        // Stray start with a different op in the last-slice cycle.
        start = 1'b1; op = ALU_ADD; add_done = 1'b1;
        add_out = {s[31:16], a[15:0]};
        @(posedge clk); #1;
        n_vec++;
        if (result_valid !== 1'b1) begin n_err++; $display("FAIL swb_valid: got %b want 1", result_valid); end
        n_vec++;
        if (result !== s) begin n_err++; $display("FAIL swb_result: got %h want %h", result, s); end
        n_vec++;
        if (cond !== 1'b1) begin n_err++; $display("FAIL swb_cond: got %b want 1", cond); end
        start = 1'b0; add_done = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (result_valid !== 1'b0) begin n_err++; $display("FAIL swb_norestart_valid: got %b want 0", result_valid); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL swb_norestart_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] a;
        logic [31:0] s;
        a = 32'h0000FFFF; s = a + 32'd1;
        start = 1'b1; op = ALU_NE; add_done = 1'b0;
        add_out = {a[31:16], s[15:0]}; a_msb = 1'b0; b_msb = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1; add_done = 1'b1;
        add_out = {s[31:16], a[15:0]};
        @(posedge clk); #1;
        n_vec++;
        if (result_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", result_valid); end
        n_vec++;
        if ({result, zero, cond, busy} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL rstmid_state: got r=%h z=%b c=%b b=%b want 0/1/0/0", result, zero, cond, busy);
        end
        rst = 1'b0; add_done = 1'b0;
        @(posedge clk); #1;
        apply_op(ALU_LTU, 32'h00000003, 32'h00000009, 1'b1);
    endtask

    task automatic test_ncyc1();
        for (int i = 0; i < 10; i++) begin
            ALUOp_t      o;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] s;
            o = ALUOp_t'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            s = ref_sum(o, a, b);
            start1 = 1'b1; op1 = o; add_done1 = 1'b1;
            add_out1 = s; a_msb1 = a[31]; b_msb1 = b[31];
            @(posedge clk); #1;
            n_vec++;
            if (result_valid1 !== 1'b1) begin n_err++; $display("FAIL n1_valid: got %b want 1", result_valid1); end
            n_vec++;
            if ({result1, zero1, cond1} !== {s, (s == 32'd0), ref_cond(o, a, b)}) begin
                n_err++; $display("FAIL n1_out: got r=%h z=%b c=%b want r=%h z=%b c=%b (op %s)",
                                  result1, zero1, cond1, s, (s == 32'd0), ref_cond(o, a, b), o.name());
            end
            start1 = 1'b0; add_done1 = 1'b0; add_out1 = $urandom;
            @(posedge clk); #1;
            n_vec++;
            if (result_valid1 !== 1'b0 || busy1 !== 1'b0) begin
                n_err++; $display("FAIL n1_pulse: got v=%b b=%b want 0/0", result_valid1, busy1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            ALUOp_t      o;
            logic [31:0] a;
            logic [31:0] b;
            o = ALUOp_t'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'd1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            apply_op(o, a, b, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_while_busy();
        test_reset_midop();
        test_ncyc1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
